// File: rtl/fsk_modulator.sv
`default_nettype none
// ============================================================================
// fsk_modulator : M-ary continuous-phase FSK transmitter (NCO + quarter-wave ROM)
// Revision      : 1.0
// ============================================================================
module fsk_modulator #(
  parameter int                 SPS      = 1024,
  parameter int                 PHASE_W  = 32,
  parameter int                 LUT_AW   = 8,
  parameter int                 AMP      = 8191,
  parameter logic [PHASE_W-1:0] BASE_INC = 'h0040_0000,
  parameter logic [PHASE_W-1:0] STEP_INC = 'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [3:0]  sym_data,
  input  logic        sym_valid,
  output logic        sym_ready,
  output logic [13:0] dac_out,
  output logic        dac_valid,
  output logic        busy,
  output logic        sym_done
);

  localparam int                CNT_W    = $clog2(SPS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Taylor series keeps the ROM contents computable at elaboration time.
  function automatic logic [12:0] lut_entry(input int idx);
    real x, term, s;
    x    = 1.57079632679489661923 * (real'(idx) + 0.5) / real'(2 ** LUT_AW);
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return 13'($rtoi(real'(AMP) * s + 0.5));
  endfunction

  logic [12:0] lut [2**LUT_AW];

  generate
    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
      localparam logic [12:0] C_VAL = lut_entry(i);
      assign lut[i] = C_VAL;
    end
  endgenerate

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W-1:0]  inc_q, inc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                s1_valid_q, s1_valid_d;
  logic [1:0]          s1_quad_q, s1_quad_d;
  logic [LUT_AW-1:0]   s1_addr_q, s1_addr_d;
  logic [13:0]         dac_out_q, dac_out_d;
  logic                dac_valid_q, dac_valid_d;
  logic                sym_done_q, sym_done_d;

  logic [3:0]          tone_k;
  logic [PHASE_W-1:0]  new_inc;
  logic                last_step;
  logic                accept;
  logic [12:0]         lut_fwd, lut_rev;

  always_comb begin
    case (mode)
      2'd0:    tone_k = sym_data & 4'h1;
      2'd1:    tone_k = sym_data & 4'h3;
      2'd2:    tone_k = sym_data & 4'h7;
      default: tone_k = sym_data;
    endcase
    new_inc   = BASE_INC + PHASE_W'(tone_k) * STEP_INC;
    last_step = (state_q == RUN) && (cnt_q == CNT_LAST);
    sym_ready = (state_q == IDLE) || last_step;
    accept    = sym_valid && sym_ready;

    state_d    = state_q;
    phase_d    = phase_q;
    inc_d      = inc_q;
    cnt_d      = cnt_q;
    sym_done_d = 1'b0;
    s1_valid_d = 1'b0;
    s1_quad_d  = phase_q[PHASE_W-1 -: 2];
    s1_addr_d  = phase_q[PHASE_W-3 -: LUT_AW];

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          phase_d = '0;
          cnt_d   = '0;
          inc_d   = new_inc;
        end
      end
      default: begin
        s1_valid_d = 1'b1;
        phase_d    = phase_q + inc_q;
        cnt_d      = cnt_q + 1'b1;
        if (last_step) begin
          sym_done_d = 1'b1;
          // Phase keeps running across a back-to-back boundary; only the tone changes.
          if (accept) begin
            inc_d = new_inc;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    lut_fwd     = lut[s1_addr_q];
    lut_rev     = lut[~s1_addr_q];
    dac_valid_d = s1_valid_q;
    dac_out_d   = '0;
    if (s1_valid_q) begin
      case (s1_quad_q)
        2'd0:    dac_out_d = {1'b0, lut_fwd};
        2'd1:    dac_out_d = {1'b0, lut_rev};
        2'd2:    dac_out_d = 14'd0 - {1'b0, lut_fwd};
        default: dac_out_d = 14'd0 - {1'b0, lut_rev};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      inc_q       <= '0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_quad_q   <= '0;
      s1_addr_q   <= '0;
      dac_out_q   <= '0;
      dac_valid_q <= 1'b0;
      sym_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      inc_q       <= inc_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_quad_q   <= s1_quad_d;
      s1_addr_q   <= s1_addr_d;
      dac_out_q   <= dac_out_d;
      dac_valid_q <= dac_valid_d;
      sym_done_q  <= sym_done_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign dac_out   = dac_out_q;
  assign dac_valid = dac_valid_q;
  assign sym_done  = sym_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fsk_modulator.sv
`default_nettype none
// ============================================================================
// tb_fsk_modulator : table-driven and randomized checks of fsk_modulator
// Revision         : 1.0
// ============================================================================
module tb_fsk_modulator;

  localparam int     SPS      = 1024;
  localparam int     AMP      = 8191;
  localparam longint BASE_INC = 'h0040_0000;
  localparam longint STEP_INC = 'h0040_0000;
  localparam real    PI       = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  sym_data = 4'd0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [13:0] dac_out;
  logic        dac_valid;
  logic        busy;
  logic        sym_done;

  fsk_modulator dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .dac_out   (dac_out),
    .dac_valid (dac_valid),
    .busy      (busy),
    .sym_done  (sym_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ideal sine sampled at the centre of each of the 4*2^LUT_AW phase bins.
  function automatic int ref_sample(input logic [31:0] p);
    int  idx;
    real x;
    idx = int'(p[31:22]);
    x   = real'(AMP) * $sin(2.0 * PI * (real'(idx) + 0.5) / 1024.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Reference model: remaining phase steps, NCO phase, 2-deep output delay.
  int          rem = 0;
  logic [31:0] p_m = '0;
  logic [31:0] inc_m = '0;
  bit          v1 = 0, v2 = 0, done_e = 0, busy_e = 0;
  int          s1 = 0, s2 = 0;
  int          cap [4096];
  int          cap_total = 0;
  int          done_total = 0;

  initial begin
    bit       step, acc;
    int       k;
    forever begin
      @(negedge clk);
      if (reset) begin
        rem = 0; p_m = '0; inc_m = '0;
        v1 = 0; v2 = 0; s1 = 0; s2 = 0; done_e = 0; busy_e = 0;
        check("rst_dac_valid", dac_valid, 0);
        check("rst_dac_out", $signed(dac_out), 0);
        check("rst_busy", busy, 0);
        check("rst_sym_done", sym_done, 0);
      end else begin
        check("sym_ready", sym_ready, (rem <= 1) ? 1 : 0);
        check("busy", busy, busy_e);
        check("sym_done", sym_done, done_e);
        check("dac_valid", dac_valid, v2);
        check("dac_out", $signed(dac_out), v2 ? s2 : 0);
        if (dac_valid) begin
          cap[cap_total % 4096] = int'($signed(dac_out));
          cap_total++;
        end
        if (sym_done) done_total++;
        step = (rem > 0);
        acc  = sym_valid && (rem <= 1);
        v2 = v1; s2 = s1; v1 = step;
        if (step) begin
          s1  = ref_sample(p_m);
          p_m = p_m + inc_m;
        end
        if (acc) begin
          k     = int'(sym_data) & ((1 << (int'(mode) + 1)) - 1);
          inc_m = 32'(BASE_INC + longint'(k) * STEP_INC);
          if (!step) p_m = '0;
        end
        done_e = (rem == 1);
        rem    = acc ? SPS : (step ? rem - 1 : 0);
        busy_e = (rem > 0);
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [3:0] d);
    bit accepted;
    accepted  = 0;
    mode      = m;
    sym_data  = d;
    sym_valid = 1'b1;
    for (int t = 0; t < 3 * SPS && !accepted; t++) begin
      @(negedge clk);
      if (sym_ready) begin
        @(posedge clk);
        #1;
        accepted = 1;
      end
    end
    sym_valid = 1'b0;
    if (!accepted) check("accept_timeout", accepted, 1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int t = 0; t < 4 * SPS && !idle; t++) begin
      @(negedge clk);
      if (!busy && !dac_valid) idle = 1;
    end
    if (!idle) check("idle_timeout", idle, 1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] m;
    logic [3:0] d;
    int         n;
    int         exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int  base, d0;
    bit  reached;
    logic [1:0] rm;
    logic [3:0] rd;

    tbl[0] = '{2'd0, 4'h0,   0,    25};
    tbl[1] = '{2'd0, 4'h0, 256,  8191};
    tbl[2] = '{2'd0, 4'h0, 512,   -25};
    tbl[3] = '{2'd0, 4'h0, 768, -8191};
    tbl[4] = '{2'd0, 4'hF, 128,  8191};
    tbl[5] = '{2'd0, 4'hF, 384, -8191};
    tbl[6] = '{2'd3, 4'hF,  16,  8191};
    tbl[7] = '{2'd3, 4'hF,  48, -8191};
    tbl[8] = '{2'd3, 4'hF,  32,   -25};
    tbl[9] = '{2'd1, 4'hF,  64,  8191};

    #22 reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      base = cap_total;
      send(tbl[i].m, tbl[i].d);
      wait_idle();
      check($sformatf("tbl%0d_count", i), cap_total - base, SPS);
      check($sformatf("tbl%0d_n%0d", i, tbl[i].n), cap[(base + tbl[i].n) % 4096], tbl[i].exp);
    end

    // Back-to-back symbols with continuous phase across the boundary.
    base = cap_total;
    d0   = done_total;
    send(2'd0, 4'h0);
    send(2'd0, 4'h1);
    wait_idle();
    check("b2b_count", cap_total - base, 2 * SPS);
    check("b2b_first_sym2", cap[(base + SPS) % 4096], 25);
    check("b2b_sym2_n128", cap[(base + SPS + 128) % 4096], 8191);
    check("b2b_done_pulses", done_total - d0, 2);

    // Idle gap, then phase restarts at zero.
    repeat (20) @(posedge clk);
    #1;
    base = cap_total;
    send(2'd2, 4'h3);
    wait_idle();
    check("gap_first", cap[base % 4096], 25);

    // Asynchronous reset in the middle of a symbol.
    base    = cap_total;
    reached = 0;
    send(2'd0, 4'h0);
    for (int t = 0; t < 2 * SPS && !reached; t++) begin
      @(negedge clk);
      if (cap_total - base >= 300) reached = 1;
    end
    check("reach_sample_300", reached, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_dac_out", $signed(dac_out), 0);
    check("async_dac_valid", dac_valid, 0);
    check("async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", sym_ready, 1);
    @(posedge clk);
    #1;
    base = cap_total;
    send(2'd0, 4'h0);
    wait_idle();
    check("post_rst_count", cap_total - base, SPS);
    check("post_rst_first", cap[base % 4096], 25);

    // Randomized symbols, mixed back-to-back and gapped, checked by the model.
    base = cap_total;
    for (int i = 0; i < 12; i++) begin
      rm = 2'($urandom_range(0, 3));
      rd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
      end
      send(rm, rd);
    end
    wait_idle();
    check("rand_count", cap_total - base, 12 * SPS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
